// File: rtl/muxa_b.sv
// Operand bus-select stage: registers the ALU operand buses from the
// register file, PC path and constant unit with a synchronous active-low reset.
module muxa_b #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] PC_M1,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic [WIDTH-1:0] SEorZF,
  input  logic             MA,
  input  logic             MB,
  output logic [WIDTH-1:0] BUS_A,
  output logic [WIDTH-1:0] BUS_B
);

  logic [WIDTH-1:0] bus_a_d, bus_a_q;
  logic [WIDTH-1:0] bus_b_d, bus_b_q;

  // Only a select that is exactly 1 picks the alternate source; X/Z/0 fall
  // through to the register-file port.
  always_comb begin
    bus_a_d = A_DATA;
    bus_b_d = B_DATA;
    if (MA == 1'b1) bus_a_d = PC_M1;
    if (MB == 1'b1) bus_b_d = SEorZF;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus_a_q <= '0;
      bus_b_q <= '0;
    end else begin
      bus_a_q <= bus_a_d;
      bus_b_q <= bus_b_d;
    end
  end

  assign BUS_A = bus_a_q;
  assign BUS_B = bus_b_q;

endmodule

// File: tb/tb_muxa_b.sv
// Bench for muxa_b: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the bus rules.
module tb_muxa_b;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [W-1:0] PC_M1, A_DATA, B_DATA, SEorZF;
  logic         MA, MB;
  logic [W-1:0] BUS_A, BUS_B;

  int checks = 0;
  int errors = 0;

  muxa_b #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .PC_M1  (PC_M1),
    .A_DATA (A_DATA),
    .B_DATA (B_DATA),
    .SEorZF (SEorZF),
    .MA     (MA),
    .MB     (MB),
    .BUS_A  (BUS_A),
    .BUS_B  (BUS_B)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: what each bus must hold after the most recent edge.
  logic [W-1:0] exp_a, exp_b;
  logic         model_ok = 1'b0;

  always @(posedge CLK) begin
    if (RST_N === 1'b0) begin
      exp_a    <= '0;
      exp_b    <= '0;
      model_ok <= 1'b1;
    end else begin
      exp_a <= (MA === 1'b1) ? PC_M1 : A_DATA;
      exp_b <= (MB === 1'b1) ? SEorZF : B_DATA;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (model_ok) begin
      check("model_bus_a", BUS_A, exp_a);
      check("model_bus_b", BUS_B, exp_b);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N  = 1'b0;
    PC_M1  = 32'hFFFF_FFFF;
    A_DATA = 32'hFFFF_FFFF;
    B_DATA = 32'hFFFF_FFFF;
    SEorZF = 32'hFFFF_FFFF;
    MA     = 1'b1;
    MB     = 1'b1;
    step();
    step();
    check("reset_a", BUS_A, 32'h0000_0000);
    check("reset_b", BUS_B, 32'h0000_0000);

    RST_N = 1'b1;
    step();
    check("first_edge_a", BUS_A, 32'hFFFF_FFFF);
    check("first_edge_b", BUS_B, 32'hFFFF_FFFF);

    PC_M1  = 32'hFFFF_FFFF;
    A_DATA = 32'hAAAA_AAAA;
    B_DATA = 32'hBBBB_BBBB;
    SEorZF = 32'h0000_0001;
    MA = 1'b0;
    MB = 1'b0;
    step();
    check("regfile_a", BUS_A, 32'hAAAA_AAAA);
    check("regfile_b", BUS_B, 32'hBBBB_BBBB);

    MA = 1'b1;
    step();
    check("ma1_a", BUS_A, 32'hFFFF_FFFF);
    check("ma1_b_hold", BUS_B, 32'hBBBB_BBBB);
    MA = 1'b0;
    step();
    check("ma0_a", BUS_A, 32'hAAAA_AAAA);
    check("ma0_b_hold", BUS_B, 32'hBBBB_BBBB);

    MB = 1'b1;
    step();
    check("mb1_b", BUS_B, 32'h0000_0001);
    check("mb1_a_hold", BUS_A, 32'hAAAA_AAAA);
    MB = 1'b0;
    step();
    check("mb0_b", BUS_B, 32'hBBBB_BBBB);
    check("mb0_a_hold", BUS_A, 32'hAAAA_AAAA);

    MA = 1'bx;
    MB = 1'bx;
    A_DATA = 32'h1234_5678;
    B_DATA = 32'h9ABC_DEF0;
    step();
    check("xsel_a", BUS_A, 32'h1234_5678);
    check("xsel_b", BUS_B, 32'h9ABC_DEF0);

    // Select and data changing together before one edge.
    MA = 1'b1;
    PC_M1 = 32'h1357_2468;
    MB = 1'b0;
    B_DATA = 32'h8000_0001;
    step();
    check("simul_a", BUS_A, 32'h1357_2468);
    check("simul_b", BUS_B, 32'h8000_0001);

    MA = 1'b1;
    MB = 1'b1;
    PC_M1  = 32'hCAFE_0001;
    SEorZF = 32'hFFFF_8000;
    step();
    check("alt_a", BUS_A, 32'hCAFE_0001);
    check("alt_b", BUS_B, 32'hFFFF_8000);
    RST_N = 1'b0;
    step();
    check("midreset_a", BUS_A, 32'h0000_0000);
    check("midreset_b", BUS_B, 32'h0000_0000);
    RST_N = 1'b1;
    step();
    check("postreset_a", BUS_A, 32'hCAFE_0001);
    check("postreset_b", BUS_B, 32'hFFFF_8000);

    // Mixed traffic covered by the per-cycle model comparison.
    for (int i = 0; i < 40; i++) begin
      PC_M1  = $urandom;
      A_DATA = $urandom;
      B_DATA = $urandom;
      SEorZF = $urandom;
      MA     = 1'($urandom_range(0, 1));
      MB     = 1'($urandom_range(0, 1));
      RST_N  = (i % 13 == 7) ? 1'b0 : 1'b1;
      step();
    end
    RST_N = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
